// File: rtl/dsp_pkg.sv
// Shared OPMODE layout, mux encodings and decode helper for the MAC pipeline.
package dsp_pkg;

  localparam int unsigned OPMODE_W    = 8;
  localparam int unsigned OP_POST_SUB = 7;
  localparam int unsigned OP_PRE_SUB  = 6;
  localparam int unsigned OP_CIN      = 5;
  localparam int unsigned OP_PRE_EN   = 4;
  localparam int unsigned OP_Z_LSB    = 2;
  localparam int unsigned OP_X_LSB    = 0;

  typedef enum logic [1:0] {
    X_ZERO = 2'b00,
    X_M    = 2'b01,
    X_P    = 2'b10,
    X_DAB  = 2'b11
  } xsel_e;

  typedef enum logic [1:0] {
    Z_ZERO = 2'b00,
    Z_PCIN = 2'b01,
    Z_P    = 2'b10,
    Z_C    = 2'b11
  } zsel_e;

  typedef struct packed {
    logic  post_sub;
    logic  pre_sub;
    logic  cin;
    logic  pre_en;
    zsel_e zsel;
    xsel_e xsel;
  } opmode_t;

  // Only the post-adder controls travel past the pre-adder stage.
  typedef struct packed {
    logic  post_sub;
    logic  cin;
    zsel_e zsel;
    xsel_e xsel;
  } post_op_t;

  function automatic opmode_t op_decode(input logic [OPMODE_W-1:0] raw);
    opmode_t op;
    op.post_sub = raw[OP_POST_SUB];
    op.pre_sub  = raw[OP_PRE_SUB];
    op.cin      = raw[OP_CIN];
    op.pre_en   = raw[OP_PRE_EN];
    op.zsel     = zsel_e'(raw[OP_Z_LSB +: 2]);
    op.xsel     = xsel_e'(raw[OP_X_LSB +: 2]);
    return op;
  endfunction

  function automatic post_op_t post_op(input opmode_t op);
    post_op_t po;
    po.post_sub = op.post_sub;
    po.cin      = op.cin;
    po.zsel     = op.zsel;
    po.xsel     = op.xsel;
    return po;
  endfunction

endpackage

// File: rtl/dsp_macc_pipe_if.sv
// Sample/result bundle of the MAC pipeline; master drives samples, slave is the slice.
interface dsp_macc_pipe_if #(
  parameter int unsigned AW = 18,
  parameter int unsigned BW = 18,
  parameter int unsigned PW = 48
) ();

  logic                ce;
  logic                in_valid;
  logic [7:0]          opmode;
  logic [AW-1:0]       a;
  logic [BW-1:0]       b;
  logic [BW-1:0]       d;
  logic [PW-1:0]       c;
  logic [PW-1:0]       pcin;
  logic                ovf_clr;
  logic                out_valid;
  logic [BW-1:0]       bcout;
  logic [AW+BW-1:0]    m;
  logic [PW-1:0]       p;
  logic [PW-1:0]       pcout;
  logic                carryout;
  logic                ovf;

  modport master (
    output ce, in_valid, opmode, a, b, d, c, pcin, ovf_clr,
    input  out_valid, bcout, m, p, pcout, carryout, ovf
  );

  modport slave (
    input  ce, in_valid, opmode, a, b, d, c, pcin, ovf_clr,
    output out_valid, bcout, m, p, pcout, carryout, ovf
  );

endinterface

// File: rtl/dsp_postadd_sat.sv
// Combinational post-adder: Z +/- (X + CIN) with carry/borrow, overflow and optional clamp.
module dsp_postadd_sat #(
  parameter int unsigned PW     = 48,
  parameter int unsigned SAT_EN = 0
) (
  input  logic [PW-1:0] x,
  input  logic [PW-1:0] z,
  input  logic          sub,
  input  logic          cin,
  output logic [PW-1:0] p_c,
  output logic          carry_c,
  output logic          ovf_c
);

  localparam int unsigned TW = PW + 1;

  logic [TW-1:0] t;

  always_comb begin
    t = sub ? TW'(z) - (TW'(x) + TW'(cin))
            : TW'(z) + TW'(x) + TW'(cin);
    carry_c = t[PW];
    ovf_c   = t[PW];
    p_c     = t[PW-1:0];
    // Clamp toward the side that overflowed: ceiling on add, floor on sub.
    if (SAT_EN != 0 && t[PW]) begin
      p_c = sub ? '0 : '1;
    end
  end

endmodule

// File: rtl/dsp_macc_pipe.sv
// Valid-tagged pre-add / multiply / post-add-accumulate pipeline with global stall.
module dsp_macc_pipe
  import dsp_pkg::*;
#(
  parameter int unsigned AW     = 18,
  parameter int unsigned BW     = 18,
  parameter int unsigned PW     = 48,
  parameter int unsigned MREG   = 1,
  parameter int unsigned SAT_EN = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  dsp_macc_pipe_if.slave bus
);

  localparam int unsigned MW    = AW + BW;
  localparam int unsigned DAB_W = 2 * BW + AW;

  // Stage 1: input capture
  logic [AW-1:0] a1;
  logic [BW-1:0] b1, d1;
  logic [PW-1:0] c1, pcin1;
  opmode_t       op1;
  logic          v1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a1    <= '0;
      b1    <= '0;
      d1    <= '0;
      c1    <= '0;
      pcin1 <= '0;
      op1   <= '0;
      v1    <= 1'b0;
    end else if (bus.ce) begin
      a1    <= bus.a;
      b1    <= bus.b;
      d1    <= bus.d;
      c1    <= bus.c;
      pcin1 <= bus.pcin;
      op1   <= op_decode(bus.opmode);
      v1    <= bus.in_valid;
    end
  end

  // Stage 2: pre-adder
  logic [BW-1:0]    pre_c;
  logic [DAB_W-1:0] dab_full_c;

  always_comb begin
    pre_c = b1;
    if (op1.pre_en) begin
      pre_c = op1.pre_sub ? d1 - b1 : d1 + b1;
    end
  end

  assign dab_full_c = {d1, a1, b1};

  logic [BW-1:0] bcout_r;
  logic [AW-1:0] a2;
  logic [PW-1:0] dab2, c2, pcin2;
  post_op_t      pop2;
  logic          v2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcout_r <= '0;
      a2      <= '0;
      dab2    <= '0;
      c2      <= '0;
      pcin2   <= '0;
      pop2    <= '0;
      v2      <= 1'b0;
    end else if (bus.ce) begin
      bcout_r <= pre_c;
      a2      <= a1;
      dab2    <= PW'(dab_full_c);
      c2      <= c1;
      pcin2   <= pcin1;
      pop2    <= post_op(op1);
      v2      <= v1;
    end
  end

  // Stage 3: multiplier, optionally registered
  logic [MW-1:0] m_c, m3;
  logic [PW-1:0] dab3, c3, pcin3;
  post_op_t      pop3;
  logic          v3;

  assign m_c = MW'(a2) * MW'(bcout_r);

  generate
    if (MREG != 0) begin : g_mreg
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          m3    <= '0;
          dab3  <= '0;
          c3    <= '0;
          pcin3 <= '0;
          pop3  <= '0;
          v3    <= 1'b0;
        end else if (bus.ce) begin
          m3    <= m_c;
          dab3  <= dab2;
          c3    <= c2;
          pcin3 <= pcin2;
          pop3  <= pop2;
          v3    <= v2;
        end
      end
    end else begin : g_mcomb
      always_comb begin
        m3    = m_c;
        dab3  = dab2;
        c3    = c2;
        pcin3 = pcin2;
        pop3  = pop2;
        v3    = v2;
      end
    end
  endgenerate

  // Stage 4: X/Z muxes feeding the post-adder; P feedback is the live P register
  logic [PW-1:0] p_r;
  logic [PW-1:0] x_c, z_c, sum_c;
  logic          co_c, ov_c;

  always_comb begin
    x_c = '0;
    case (pop3.xsel)
      X_ZERO:  x_c = '0;
      X_M:     x_c = PW'(m3);
      X_P:     x_c = p_r;
      X_DAB:   x_c = dab3;
      default: x_c = '0;
    endcase
  end

  always_comb begin
    z_c = '0;
    case (pop3.zsel)
      Z_ZERO:  z_c = '0;
      Z_PCIN:  z_c = pcin3;
      Z_P:     z_c = p_r;
      Z_C:     z_c = c3;
      default: z_c = '0;
    endcase
  end

  dsp_postadd_sat #(
    .PW     (PW),
    .SAT_EN (SAT_EN)
  ) u_postadd (
    .x       (x_c),
    .z       (z_c),
    .sub     (pop3.post_sub),
    .cin     (pop3.cin),
    .p_c     (sum_c),
    .carry_c (co_c),
    .ovf_c   (ov_c)
  );

  logic out_valid_r, carry_r, ovf_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      p_r         <= '0;
      carry_r     <= 1'b0;
      ovf_r       <= 1'b0;
    end else if (bus.ce) begin
      out_valid_r <= v3;
      if (v3) begin
        p_r     <= sum_c;
        carry_r <= co_c;
      end
      // A new overflow beats a clear arriving on the same edge.
      if (v3 && ov_c) begin
        ovf_r <= 1'b1;
      end else if (bus.ovf_clr) begin
        ovf_r <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.bcout     = bcout_r;
  assign bus.m         = m3;
  assign bus.p         = p_r;
  assign bus.pcout     = p_r;
  assign bus.carryout  = carry_r;
  assign bus.ovf       = ovf_r;

endmodule

// File: tb/tb_dsp_macc_pipe.sv
// Bench for dsp_macc_pipe: wrapping and saturating slices share one stimulus stream.
module tb_dsp_macc_pipe;

  localparam int unsigned AW = 18;
  localparam int unsigned BW = 18;
  localparam int unsigned PW = 48;
  localparam int unsigned MW = AW + BW;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  dsp_macc_pipe_if #(.AW(AW), .BW(BW), .PW(PW)) bus0 ();
  dsp_macc_pipe_if #(.AW(AW), .BW(BW), .PW(PW)) bus1 ();

  dsp_macc_pipe #(.AW(AW), .BW(BW), .PW(PW), .MREG(1), .SAT_EN(0)) dut_wrap (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  dsp_macc_pipe #(.AW(AW), .BW(BW), .PW(PW), .MREG(1), .SAT_EN(1)) dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  assign bus1.ce       = bus0.ce;
  assign bus1.in_valid = bus0.in_valid;
  assign bus1.opmode   = bus0.opmode;
  assign bus1.a        = bus0.a;
  assign bus1.b        = bus0.b;
  assign bus1.d        = bus0.d;
  assign bus1.c        = bus0.c;
  assign bus1.pcin     = bus0.pcin;
  assign bus1.ovf_clr  = bus0.ovf_clr;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: every accepted sample is evaluated from the arithmetic rules
  // at acceptance time and scheduled to appear three enabled edges later.
  typedef struct packed {
    logic [PW-1:0] p0;
    logic [PW-1:0] p1;
    logic          co0;
    logic          co1;
  } res_t;

  int            ecnt;
  logic [BW-1:0] bc_q [int];
  logic [MW-1:0] m_q  [int];
  res_t          res_q[int];
  logic [PW-1:0] mp0, mp1;
  logic          cur_valid;
  logic [PW-1:0] cur_p0, cur_p1;
  logic          cur_co0, cur_co1, cur_ov0, cur_ov1;
  logic [BW-1:0] cur_bc;
  logic [MW-1:0] cur_m;

  function automatic void ref_post(input logic [7:0] op, input longint m, input longint dab,
                                   input longint c, input longint pcin, input longint pfb,
                                   input bit sat, output logic [PW-1:0] p, output logic co);
    longint x, z, t, lim;
    lim = longint'(1) << PW;
    case (op[1:0])
      2'd0:    x = 0;
      2'd1:    x = m;
      2'd2:    x = pfb;
      default: x = dab;
    endcase
    case (op[3:2])
      2'd0:    z = 0;
      2'd1:    z = pcin;
      2'd2:    z = pfb;
      default: z = c;
    endcase
    if (op[7]) begin
      t  = z - x - longint'(op[5]);
      co = (t < 0);
    end else begin
      t  = z + x + longint'(op[5]);
      co = (t >= lim);
    end
    if (sat && co) p = op[7] ? '0 : '1;
    else           p = PW'(t);
  endfunction

  longint la, lb, ld, pre, lmask;
  res_t   r;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ecnt = 0;
      bc_q.delete();
      m_q.delete();
      res_q.delete();
      mp0 = '0; mp1 = '0;
      cur_valid = 1'b0;
      cur_p0 = '0; cur_p1 = '0;
      cur_co0 = 1'b0; cur_co1 = 1'b0;
      cur_ov0 = 1'b0; cur_ov1 = 1'b0;
      cur_bc = '0; cur_m = '0;
    end else if (bus0.ce) begin
      ecnt++;
      la    = longint'(bus0.a);
      lb    = longint'(bus0.b);
      ld    = longint'(bus0.d);
      lmask = (longint'(1) << BW) - 1;
      if (bus0.opmode[4]) pre = bus0.opmode[6] ? (ld - lb) & lmask : (ld + lb) & lmask;
      else                pre = lb;
      bc_q[ecnt + 1] = BW'(pre);
      m_q[ecnt + 2]  = MW'(la * pre);
      if (bus0.in_valid) begin
        ref_post(bus0.opmode, la * pre,
                 ((ld << (AW + BW)) | (la << BW) | lb) & ((longint'(1) << PW) - 1),
                 longint'(bus0.c), longint'(bus0.pcin), longint'(mp0), 1'b0, r.p0, r.co0);
        ref_post(bus0.opmode, la * pre,
                 ((ld << (AW + BW)) | (la << BW) | lb) & ((longint'(1) << PW) - 1),
                 longint'(bus0.c), longint'(bus0.pcin), longint'(mp1), 1'b1, r.p1, r.co1);
        mp0 = r.p0;
        mp1 = r.p1;
        res_q[ecnt + 3] = r;
      end
      cur_bc = bc_q.exists(ecnt) ? bc_q[ecnt] : '0;
      cur_m  = m_q.exists(ecnt)  ? m_q[ecnt]  : '0;
      bc_q.delete(ecnt);
      m_q.delete(ecnt);
      if (res_q.exists(ecnt)) begin
        cur_valid = 1'b1;
        cur_p0  = res_q[ecnt].p0;
        cur_p1  = res_q[ecnt].p1;
        cur_co0 = res_q[ecnt].co0;
        cur_co1 = res_q[ecnt].co1;
        cur_ov0 = res_q[ecnt].co0 | (cur_ov0 & ~bus0.ovf_clr);
        cur_ov1 = res_q[ecnt].co1 | (cur_ov1 & ~bus0.ovf_clr);
        res_q.delete(ecnt);
      end else begin
        cur_valid = 1'b0;
        cur_ov0 = cur_ov0 & ~bus0.ovf_clr;
        cur_ov1 = cur_ov1 & ~bus0.ovf_clr;
      end
    end
  end

  // Every output of both slices is compared against the model each negedge.
  always @(negedge clk) begin
    check("valid_wrap",  64'(bus0.out_valid), 64'(cur_valid));
    check("p_wrap",      64'(bus0.p),         64'(cur_p0));
    check("pcout_wrap",  64'(bus0.pcout),     64'(cur_p0));
    check("carry_wrap",  64'(bus0.carryout),  64'(cur_co0));
    check("ovf_wrap",    64'(bus0.ovf),       64'(cur_ov0));
    check("bcout_wrap",  64'(bus0.bcout),     64'(cur_bc));
    check("m_wrap",      64'(bus0.m),         64'(cur_m));
    check("valid_sat",   64'(bus1.out_valid), 64'(cur_valid));
    check("p_sat",       64'(bus1.p),         64'(cur_p1));
    check("pcout_sat",   64'(bus1.pcout),     64'(cur_p1));
    check("carry_sat",   64'(bus1.carryout),  64'(cur_co1));
    check("ovf_sat",     64'(bus1.ovf),       64'(cur_ov1));
    check("bcout_sat",   64'(bus1.bcout),     64'(cur_bc));
    check("m_sat",       64'(bus1.m),         64'(cur_m));
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic rand_inputs();
    bus0.in_valid = ($urandom_range(0, 3) != 0);
    bus0.opmode   = 8'($urandom);
    bus0.a        = AW'($urandom);
    bus0.b        = BW'($urandom);
    bus0.d        = BW'($urandom);
    bus0.c        = PW'({$urandom(), $urandom()});
    bus0.pcin     = PW'({$urandom(), $urandom()});
  endtask

  task automatic drive(input logic [7:0] op, input logic [AW-1:0] a, input logic [BW-1:0] b,
                       input logic [BW-1:0] d, input logic [PW-1:0] c);
    bus0.in_valid = 1'b1;
    bus0.opmode   = op;
    bus0.a        = a;
    bus0.b        = b;
    bus0.d        = d;
    bus0.c        = c;
    bus0.pcin     = '0;
  endtask

  task automatic run_one();
    step();
    bus0.in_valid = 1'b0;
    repeat (3) step();
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    bus0.ce      = 1'b1;
    bus0.ovf_clr = 1'b0;
    rand_inputs();
    #1 rst_n = 1'b0;

    // Reset with live random inputs and CE high
    repeat (3) begin
      rand_inputs();
      step();
    end
    check("rst_valid", 64'(bus0.out_valid), 64'd0);
    check("rst_p",     64'(bus1.p),         64'd0);
    check("rst_pcout", 64'(bus0.pcout),     64'd0);
    check("rst_m",     64'(bus0.m),         64'd0);
    check("rst_bcout", 64'(bus1.bcout),     64'd0);
    check("rst_carry", 64'(bus0.carryout),  64'd0);
    check("rst_ovf",   64'(bus1.ovf),       64'd0);
    bus0.in_valid = 1'b0;
    rst_n = 1'b1;
    step();

    // Pre-subtract into post-subtract: C - A*(D-B)
    drive(8'b1101_1101, 18'd20, 18'd10, 18'd25, 48'd350);
    run_one();
    check("presub_bcout", 64'(bus0.bcout),    64'd15);
    check("presub_m",     64'(bus0.m),        64'h12C);
    check("presub_p",     64'(bus0.p),        64'h32);
    check("presub_carry", 64'(bus0.carryout), 64'd0);
    check("presub_p_sat", 64'(bus1.p),        64'h32);

    // Pre-add, X=M only
    drive(8'b0001_0001, 18'd20, 18'd10, 18'd25, 48'd0);
    run_one();
    check("preadd_bcout", 64'(bus0.bcout), 64'h23);
    check("preadd_m",     64'(bus0.m),     64'h2BC);
    check("preadd_p",     64'(bus1.p),     64'h2BC);

    // Back-to-back accumulation through the P feedback
    reset_pulse();
    drive(8'b0000_1001, 18'd2, 18'd3, 18'd0, 48'd0);
    repeat (3) step();
    step();
    check("acc_p1", 64'(bus0.p), 64'd6);
    bus0.in_valid = 1'b0;
    step();
    check("acc_p2", 64'(bus0.p), 64'd12);
    step();
    check("acc_p3", 64'(bus1.p), 64'd18);
    step();
    check("acc_p4", 64'(bus0.p), 64'd24);
    check("acc_valid", 64'(bus0.out_valid), 64'd1);
    step();
    check("acc_bubble_p", 64'(bus0.p),         64'd24);
    check("acc_bubble_v", 64'(bus0.out_valid), 64'd0);

    // Add overflow: wrap vs clamp to all ones
    reset_pulse();
    drive(8'b0000_1101, 18'd20, 18'd1, 18'd0, 48'hFFFF_FFFF_FFF6);
    run_one();
    check("ovadd_p_wrap",   64'(bus0.p),        64'hA);
    check("ovadd_co_wrap",  64'(bus0.carryout), 64'd1);
    check("ovadd_ovf_wrap", 64'(bus0.ovf),      64'd1);
    check("ovadd_p_sat",    64'(bus1.p),        64'hFFFF_FFFF_FFFF);
    check("ovadd_ovf_sat",  64'(bus1.ovf),      64'd1);
    bus0.ovf_clr = 1'b1;
    step();
    bus0.ovf_clr = 1'b0;
    check("ovf_cleared", 64'(bus1.ovf), 64'd0);

    // Subtract underflow: wrap vs clamp to zero
    drive(8'b1000_1101, 18'd6, 18'd1, 18'd0, 48'd5);
    run_one();
    check("ovsub_p_sat",   64'(bus1.p),        64'd0);
    check("ovsub_ovf_sat", 64'(bus1.ovf),      64'd1);
    check("ovsub_p_wrap",  64'(bus0.p),        64'hFFFF_FFFF_FFFF);
    check("ovsub_co_wrap", 64'(bus0.carryout), 64'd1);

    // Randomized stream with stalls, overflow clears and occasional reset pulses
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      bus0.ovf_clr = ($urandom_range(0, 9) == 0);
      if ((i % 97) >= 40 && (i % 97) < 43) bus0.ce = 1'b0;
      else                                 bus0.ce = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 249) == 0) rst_n = 1'b0;
      step();
      rst_n = 1'b1;
    end

    bus0.ce       = 1'b1;
    bus0.in_valid = 1'b0;
    bus0.ovf_clr  = 1'b0;
    repeat (6) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
